// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush control for the 5-stage pipeline: per-stage enables and bubbles,
// a small FSM for outstanding data-memory misses and killed fetches, plus perf counters.
module pipeline_stall_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 lu_stall,
    input  logic                 redirect_valid,
    input  logic                 imem_valid,
    input  logic                 dmem_req,
    input  logic                 dmem_resp,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 if_id_flush,
    output logic                 id_ex_en,
    output logic                 id_ex_flush,
    output logic                 ex_mem_en,
    output logic                 mem_wb_en,
    output logic                 mem_wb_bubble,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        DMEM_WAIT  = 2'd1,
        FETCH_KILL = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] stall_q, stall_d;
    logic [CNT_WIDTH-1:0] flush_q, flush_d;
    logic                 flush_inc;
    logic                 miss;

    assign miss = dmem_req & ~dmem_resp;

    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        mem_wb_bubble = 1'b0;
        flush_inc     = 1'b0;
        state_d       = state_q;

        if (!reset_n) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_en     = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            mem_wb_bubble = 1'b1;
            state_d       = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (miss) begin
                        pc_en         = 1'b0;
                        if_id_en      = 1'b0;
                        id_ex_en      = 1'b0;
                        ex_mem_en     = 1'b0;
                        mem_wb_en     = 1'b0;
                        mem_wb_bubble = 1'b1;
                        state_d       = DMEM_WAIT;
                    end else if (redirect_valid) begin
                        // The ID instruction is wrong-path, so a load-use hazard on it is moot.
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        flush_inc   = 1'b1;
                        if (!imem_valid)
                            state_d = FETCH_KILL;
                    end else if (lu_stall) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end else if (!imem_valid) begin
                        pc_en       = 1'b0;
                        if_id_flush = 1'b1;
                    end
                end
                DMEM_WAIT: begin
                    if (!dmem_resp) begin
                        pc_en         = 1'b0;
                        if_id_en      = 1'b0;
                        id_ex_en      = 1'b0;
                        ex_mem_en     = 1'b0;
                        mem_wb_en     = 1'b0;
                        mem_wb_bubble = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
                FETCH_KILL: begin
                    if (miss) begin
                        // Frozen: the old-path beat cannot be dropped yet, so stay in the kill state.
                        pc_en         = 1'b0;
                        if_id_en      = 1'b0;
                        id_ex_en      = 1'b0;
                        ex_mem_en     = 1'b0;
                        mem_wb_en     = 1'b0;
                        mem_wb_bubble = 1'b1;
                    end else if (redirect_valid) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        flush_inc   = 1'b1;
                    end else begin
                        pc_en       = 1'b0;
                        if_id_flush = 1'b1;
                        if (imem_valid)
                            state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (!pc_en && (stall_q != {CNT_WIDTH{1'b1}}))
            stall_d = stall_q + CNT_WIDTH'(1);
        if (flush_inc && (flush_q != {CNT_WIDTH{1'b1}}))
            flush_d = flush_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl with 4-bit counters so saturation is reachable.
module tb_pipeline_stall_ctrl;

    localparam int CW = 4;

    // Output vector order: pc, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem, mem_wb, bubble
    localparam logic [7:0] V_NORMAL = 8'b11010110;
    localparam logic [7:0] V_RESET  = 8'b00101001;
    localparam logic [7:0] V_FREEZE = 8'b00000001;
    localparam logic [7:0] V_REDIR  = 8'b11111110;
    localparam logic [7:0] V_LU     = 8'b00011110;
    localparam logic [7:0] V_FEMPTY = 8'b01110110;
    localparam logic [7:0] V_KILL   = 8'b01110110;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          lu_stall, redirect_valid, imem_valid, dmem_req, dmem_resp;
    logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic          ex_mem_en, mem_wb_en, mem_wb_bubble;
    logic [CW-1:0] stall_cycles, flush_count;
    logic [7:0]    outs;

    int chk_cnt = 0;
    int err_cnt = 0;

    pipeline_stall_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .lu_stall       (lu_stall),
        .redirect_valid (redirect_valid),
        .imem_valid     (imem_valid),
        .dmem_req       (dmem_req),
        .dmem_resp      (dmem_resp),
        .pc_en          (pc_en),
        .if_id_en       (if_id_en),
        .if_id_flush    (if_id_flush),
        .id_ex_en       (id_ex_en),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_en      (ex_mem_en),
        .mem_wb_en      (mem_wb_en),
        .mem_wb_bubble  (mem_wb_bubble),
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
    );

    always #5 clk = ~clk;

    assign outs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                   ex_mem_en, mem_wb_en, mem_wb_bubble};

    task automatic chk_out(input string tag, input logic [7:0] exp);
        chk_cnt++;
        assert (outs === exp)
        else begin
            err_cnt++;
            $error("FAIL %s: outputs observed=%b expected=%b", tag, outs, exp);
        end
        $display("check %s outputs=%b", tag, outs);
    endtask

    task automatic chk_cnts(input string tag, input logic [CW-1:0] exp_stall,
                            input logic [CW-1:0] exp_flush);
        chk_cnt++;
        assert (stall_cycles === exp_stall && flush_count === exp_flush)
        else begin
            err_cnt++;
            $error("FAIL %s: stall/flush observed=%0d/%0d expected=%0d/%0d",
                   tag, stall_cycles, flush_count, exp_stall, exp_flush);
        end
        $display("check %s stall=%0d flush=%0d", tag, stall_cycles, flush_count);
    endtask

    // Drive inputs one time unit after the edge; outputs are sampled one unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lu, input logic rd, input logic iv,
                         input logic dq, input logic dr);
        lu_stall       = lu;
        redirect_valid = rd;
        imem_valid     = iv;
        dmem_req       = dq;
        dmem_resp      = dr;
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 1, 0, 0);
        chk_out("reset_outputs", V_RESET);
        chk_cnts("reset_counters", 4'd0, 4'd0);
        tick(); tick();
        reset_n = 1'b1;
        drive(0, 0, 1, 0, 0);
        chk_out("run_idle", V_NORMAL);
        chk_cnts("run_idle_cnt", 4'd0, 4'd0);

        // Data-memory miss: three frozen cycles then response
        tick(); drive(0, 0, 1, 1, 0); chk_out("freeze_run", V_FREEZE);
        tick(); drive(1, 0, 1, 1, 0); chk_out("dwait_ignore_lu", V_FREEZE);
        tick(); drive(0, 0, 1, 1, 0); chk_out("dwait_hold", V_FREEZE);
        tick(); drive(0, 0, 1, 1, 1); chk_out("dwait_resp", V_NORMAL);
        chk_cnts("miss_stalls", 4'd3, 4'd0);
        tick(); drive(0, 0, 1, 0, 0); chk_out("back_to_run", V_NORMAL);

        // Hit: request and response together never stall
        tick(); drive(0, 0, 1, 1, 1); chk_out("dmem_hit", V_NORMAL);

        // Single-cycle load-use
        tick(); drive(1, 0, 1, 0, 0); chk_out("load_use", V_LU);
        tick(); drive(0, 0, 1, 0, 0); chk_out("after_lu", V_NORMAL);
        chk_cnts("lu_stall_cnt", 4'd4, 4'd0);

        // Redirect wins over load-use
        tick(); drive(1, 1, 1, 0, 0); chk_out("redirect_over_lu", V_REDIR);
        tick(); drive(0, 0, 1, 0, 0); chk_out("after_redirect", V_NORMAL);
        chk_cnts("redirect_cnt", 4'd4, 4'd1);

        // Fetch empty
        tick(); drive(0, 0, 0, 0, 0); chk_out("fetch_empty", V_FEMPTY);
        tick(); drive(0, 0, 1, 0, 0); chk_out("after_fempty", V_NORMAL);
        chk_cnts("fempty_cnt", 4'd5, 4'd1);

        // Redirect with fetch in flight: three kill cycles
        tick(); drive(0, 1, 0, 0, 0); chk_out("redirect_kill", V_REDIR);
        tick(); drive(0, 0, 0, 0, 0); chk_out("kill_1", V_KILL);
        chk_cnts("kill_1_cnt", 4'd5, 4'd2);
        tick(); drive(0, 0, 0, 0, 0); chk_out("kill_2", V_KILL);
        tick(); drive(0, 0, 1, 0, 0); chk_out("kill_stale_beat", V_KILL);
        tick(); drive(0, 0, 1, 0, 0); chk_out("kill_done", V_NORMAL);
        chk_cnts("kill_cnt", 4'd8, 4'd2);

        // Redirect inside FETCH_KILL keeps the state
        tick(); drive(0, 1, 0, 0, 0); chk_out("rk_enter", V_REDIR);
        tick(); drive(0, 1, 0, 0, 0); chk_out("rk_redirect", V_REDIR);
        tick(); drive(0, 0, 0, 0, 0); chk_out("rk_still_kill", V_KILL);
        chk_cnts("rk_cnt", 4'd8, 4'd4);
        tick(); drive(0, 0, 1, 0, 0); chk_out("rk_stale", V_KILL);
        tick(); drive(0, 0, 1, 0, 0); chk_out("rk_done", V_NORMAL);
        chk_cnts("rk_done_cnt", 4'd10, 4'd4);

        // Freeze inside FETCH_KILL overrides outputs but keeps the kill state
        tick(); drive(0, 1, 0, 0, 0); chk_out("fk_enter", V_REDIR);
        tick(); drive(0, 0, 0, 1, 0); chk_out("fk_freeze", V_FREEZE);
        tick(); drive(0, 0, 1, 0, 0); chk_out("fk_after_freeze", V_KILL);
        tick(); drive(0, 0, 1, 0, 0); chk_out("fk_done", V_NORMAL);
        chk_cnts("fk_cnt", 4'd12, 4'd5);

        // Saturation of both counters
        for (int i = 0; i < 20; i++) begin
            tick(); drive(1, 0, 1, 0, 0);
        end
        for (int i = 0; i < 12; i++) begin
            tick(); drive(0, 1, 1, 0, 0);
        end
        tick(); drive(0, 0, 1, 0, 0);
        chk_out("sat_run", V_NORMAL);
        chk_cnts("saturate", 4'd15, 4'd15);

        // Asynchronous reset in the middle of a miss
        tick(); drive(0, 0, 1, 1, 0); chk_out("pre_reset_freeze", V_FREEZE);
        tick(); drive(0, 0, 1, 1, 0); chk_out("pre_reset_dwait", V_FREEZE);
        reset_n = 1'b0;
        #1;
        chk_out("async_reset", V_RESET);
        chk_cnts("async_reset_cnt", 4'd0, 4'd0);
        tick();
        reset_n = 1'b1;
        drive(0, 0, 1, 0, 0);
        chk_out("post_reset_run", V_NORMAL);
        tick(); drive(0, 0, 1, 0, 0);
        chk_cnts("post_reset_cnt", 4'd0, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
